mm_access: RTL and testbench
============================

MM_ACCESS -- requirements
Module: mm_access

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 mem_access_type  input  2  access direction from EX: 0 = R2R (no memory), 1 = M2R (load), 2 = R2M (store); 3 is treated as R2R.
REQ-004 mem_access_size  input  3  access size: 0 = BYTE, 1 = HALF, 2 = WORD, 3 = LEFT (LWL/SWL), 4 = RIGHT (LWR/SWR); 5-7 are treated as WORD.
REQ-005 mem_sign_ext  input  1  load sign-extension for BYTE/HALF: 1 = LB/LH, 0 = LBU/LHU.
REQ-006 mem_access_addr  input  32  effective byte address.
REQ-007 val_input  input  32  R2R result, store data, or old rt value for LEFT/RIGHT loads.
REQ-008 reg_addr_in  input  5  destination register.
REQ-009 bus_req / bus_wr  output  1 / 1  bus request; 1 = write.
REQ-010 bus_addr  output  32  word address {addr[31:2], 2'b00}.
REQ-011 bus_byte_en  output  4  lane enables, bit i = byte lane i (little-endian).
REQ-012 bus_wdata  output  32  lane-aligned store data.
REQ-013 bus_rdata  input  32  read data, valid when bus_ack = 1.
REQ-014 bus_ack  input  1  one-cycle completion strobe.
REQ-015 val_output / reg_addr_out / reg_we  output  32 / 5 / 1  writeback result, destination, and write enable.
REQ-016 stall_for_mem  output  1  combinational; upstream holds all inputs while it is high.
REQ-017 addr_error / bad_vaddr  output  1 / 32  misalignment flag and the faulting address.

Function
REQ-018 Two states SHALL exist: IDLE and BUSY.
REQ-019 IDLE, R2R: at the edge, val_output <= val_input and reg_addr_out <= reg_addr_in; reg_we <= (reg_addr_in != 0); no bus activity.
REQ-020 IDLE, load/store aligned: stall_for_mem = 1; at the edge, go to BUSY and register bus_req = 1, bus_wr, bus_addr, bus_byte_en, bus_wdata; reg_we <= 0.
REQ-021 Misaligned = HALF with addr[0] = 1, or WORD with addr[1:0] ≠ 0. LEFT and RIGHT are never misaligned.
REQ-022 IDLE, misaligned: no stall and no bus request; at the edge, addr_error <= 1 for one cycle, bad_vaddr <= addr, reg_we <= 0.
REQ-023 BUSY, bus_ack = 0: stall_for_mem = 1; bus outputs hold; reg_we = 0.
REQ-024 BUSY, bus_ack = 1: stall_for_mem = 0; at the edge, go to IDLE and bus_req <= 0.
  - Load: reg_we <= (reg_addr_in != 0), val_output <= formatted data.
  - Store: reg_we <= 0.
REQ-025 Let n = addr[1:0]. bus_byte_en SHALL be:
  - BYTE: 1 << n
  - HALF: n[1] ? 1100 : 0011
  - WORD: 1111
  - LEFT: n = 0..3 -> 0001 / 0011 / 0111 / 1111
  - RIGHT: n = 0..3 -> 1111 / 1110 / 1100 / 1000
REQ-026 bus_wdata SHALL be:
  - BYTE: {4{val_input[7:0]}}
  - HALF: {2{val_input[15:0]}}
  - WORD: val_input
  - LEFT: val_input >> 8*(3-n)
  - RIGHT: val_input << 8*n
REQ-027 Load formatting SHALL be:
  - BYTE: lane n, extended per mem_sign_ext.
  - HALF: lanes selected by n[1], extended per mem_sign_ext.
  - WORD: bus_rdata unchanged.
  - LEFT: (rdata << 8*(3-n)) | (val_input & (FFFFFFFF >> 8*(n+1))); the mask is 0 when n = 3.
  - RIGHT: (rdata >> 8*n) | (val_input & ~(FFFFFFFF >> 8*n)).
REQ-028 bus_ack while IDLE SHALL be ignored.
REQ-029 A new request SHALL NOT issue in the cycle following a completion edge, because state is IDLE and the request is registered; minimum load/store latency is 2 cycles, input to reg_we.

Reset
REQ-030 When rst_n = 0, state, bus_req, bus_wr, bus_addr, bus_byte_en, bus_wdata, val_output, reg_addr_out, reg_we, addr_error and bad_vaddr SHALL go to 0 immediately; state SHALL go to IDLE.
REQ-031 A reset during BUSY SHALL abandon the access; a bus_ack arriving after reset release SHALL have no effect.

Verification
REQ-032 R2R, val_input = 0x12345678, reg_addr_in = 5 -> next cycle val_output = 0x12345678, reg_addr_out = 5, reg_we = 1, stall_for_mem never high.
REQ-033 LB, addr = 0x1003, mem_sign_ext = 1, rdata = 0x80FFFFFF, ack after 3 BUSY cycles -> bus_addr = 0x1000, byte_en = 1000, stall high for 4 cycles, val_output = 0xFFFFFF80, reg_we = 1.
REQ-034 SH, addr = 0x2002, val_input = 0xAAAA1234 -> bus_wr = 1, byte_en = 1100, wdata = 0x12341234; reg_we stays 0.
REQ-035 LW, addr = 0x3001 -> addr_error pulses 1 cycle, bad_vaddr = 0x3001, bus_req stays 0, no stall.
REQ-036 LWL, n = 1, val_input = 0xAABBCCDD, rdata = 0x11223344 -> val_output = 0x3344CCDD.
  - SWR, n = 2, val_input = 0xAABBCCDD -> byte_en = 1100, wdata = 0xCCDD0000.
REQ-037 rst_n low during BUSY, then an ack after release -> bus_req = 0 immediately, reg_we stays 0, state IDLE.

Source files
------------

// File: rtl/mm_access.sv
// Memory-access stage: turns EX load/store requests into a single registered
// bus transaction, formats load data for writeback, passes R2R results
// through, and flags misaligned HALF/WORD accesses instead of issuing them.
//
// Handshake: bus_req/bus_wr/bus_addr/bus_byte_en/bus_wdata are registered and
// held stable from the edge that enters BUSY until the edge that sees
// bus_ack = 1. bus_ack is a one-cycle completion strobe that is honoured only
// in BUSY. stall_for_mem is combinational, and while it is high the upstream
// stage holds every input of this block constant.
module mm_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mem_access_type,
  input  logic [2:0]  mem_access_size,
  input  logic        mem_sign_ext,
  input  logic [31:0] mem_access_addr,
  input  logic [31:0] val_input,
  input  logic [4:0]  reg_addr_in,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byte_en,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] val_output,
  output logic [4:0]  reg_addr_out,
  output logic        reg_we,
  output logic        stall_for_mem,
  output logic        addr_error,
  output logic [31:0] bad_vaddr,
  output logic        fsm_state
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [1:0]  T_LOAD   = 2'd1;
  localparam logic [1:0]  T_STORE  = 2'd2;
  localparam logic [2:0]  SZ_BYTE  = 3'd0;
  localparam logic [2:0]  SZ_HALF  = 3'd1;
  localparam logic [2:0]  SZ_WORD  = 3'd2;
  localparam logic [2:0]  SZ_LEFT  = 3'd3;
  localparam logic [2:0]  SZ_RIGHT = 3'd4;
  localparam logic [31:0] ONES     = 32'hFFFF_FFFF;

  state_t      state;
  state_t      next_state;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic [2:0]  size_eff;
  logic [1:0]  n;
  logic [4:0]  sh_n;      // 8*n
  logic [4:0]  sh_ln;     // 8*(3-n)
  logic        misaligned;
  logic [3:0]  byte_en;
  logic [31:0] wdata;
  logic [31:0] load_data;
  logic [31:0] rdata_shr;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Decode the request; sizes 5-7 behave as WORD, type 3 behaves as R2R.
  always_comb begin
    is_load    = (mem_access_type == T_LOAD);
    is_store   = (mem_access_type == T_STORE);
    is_mem     = is_load || is_store;
    size_eff   = (mem_access_size > SZ_RIGHT) ? SZ_WORD : mem_access_size;
    n          = mem_access_addr[1:0];
    sh_n       = {n, 3'b000};
    sh_ln      = {~n, 3'b000};
    misaligned = ((size_eff == SZ_HALF) && n[0]) ||
                 ((size_eff == SZ_WORD) && (n != 2'd0));
  end

  // Lane enables, lane-aligned store data and formatted load data.
  always_comb begin
    byte_en   = 4'b1111;
    wdata     = val_input;
    load_data = bus_rdata;
    rdata_shr = bus_rdata >> sh_n;
    lane_byte = rdata_shr[7:0];
    lane_half = n[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_eff)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << n;
        wdata     = {4{val_input[7:0]}};
        load_data = {{24{mem_sign_ext & lane_byte[7]}}, lane_byte};
      end
      SZ_HALF: begin
        byte_en   = n[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{val_input[15:0]}};
        load_data = {{16{mem_sign_ext & lane_half[15]}}, lane_half};
      end
      SZ_LEFT: begin
        byte_en   = 4'b1111 >> (2'd3 - n);
        wdata     = val_input >> sh_ln;
        // Keep the low rt bytes not covered by memory; none when n = 3.
        load_data = (bus_rdata << sh_ln) | (val_input & ((ONES >> sh_n) >> 8));
      end
      SZ_RIGHT: begin
        byte_en   = 4'b1111 << n;
        wdata     = val_input << sh_n;
        load_data = rdata_shr | (val_input & ~(ONES >> sh_n));
      end
      default: begin
        byte_en   = 4'b1111;
        wdata     = val_input;
        load_data = bus_rdata;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and stall: stall while a request is being launched or waited on.
  always_comb begin
    next_state    = state;
    stall_for_mem = 1'b0;
    if (state == IDLE) begin
      if (is_mem && !misaligned) begin
        next_state    = BUSY;
        stall_for_mem = 1'b1;
      end
    end else begin
      if (bus_ack) next_state    = IDLE;
      else         stall_for_mem = 1'b1;
    end
  end

  assign fsm_state = (state == BUSY);

  // Registered bus, writeback and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req      <= 1'b0;
      bus_wr       <= 1'b0;
      bus_addr     <= 32'd0;
      bus_byte_en  <= 4'd0;
      bus_wdata    <= 32'd0;
      val_output   <= 32'd0;
      reg_addr_out <= 5'd0;
      reg_we       <= 1'b0;
      addr_error   <= 1'b0;
      bad_vaddr    <= 32'd0;
    end else begin
      addr_error <= 1'b0;
      if (state == IDLE) begin
        if (!is_mem) begin
          val_output   <= val_input;
          reg_addr_out <= reg_addr_in;
          reg_we       <= (reg_addr_in != 5'd0);
        end else if (misaligned) begin
          addr_error <= 1'b1;
          bad_vaddr  <= mem_access_addr;
          reg_we     <= 1'b0;
        end else begin
          bus_req     <= 1'b1;
          bus_wr      <= is_store;
          bus_addr    <= {mem_access_addr[31:2], 2'b00};
          bus_byte_en <= byte_en;
          bus_wdata   <= wdata;
          reg_we      <= 1'b0;
        end
      end else begin
        if (bus_ack) begin
          bus_req <= 1'b0;
          if (is_load) begin
            reg_we       <= (reg_addr_in != 5'd0);
            val_output   <= load_data;
            reg_addr_out <= reg_addr_in;
          end else begin
            reg_we <= 1'b0;
          end
        end else begin
          reg_we <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mm_access.sv
// Bench for mm_access: directed vector table, randomized accesses checked
// against a byte-lane model, plus reset and idle-ack sequences.
module tb_mm_access;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mem_access_type;
  logic [2:0]  mem_access_size;
  logic        mem_sign_ext;
  logic [31:0] mem_access_addr;
  logic [31:0] val_input;
  logic [4:0]  reg_addr_in;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byte_en;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] val_output;
  logic [4:0]  reg_addr_out;
  logic        reg_we;
  logic        stall_for_mem;
  logic        addr_error;
  logic [31:0] bad_vaddr;
  logic        fsm_state;

  int checks;
  int failures;

  typedef struct {
    logic [1:0]  typ;
    logic [2:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] val;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          delay;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs[$];

  mm_access dut (
    .clk(clk), .rst_n(rst_n),
    .mem_access_type(mem_access_type), .mem_access_size(mem_access_size),
    .mem_sign_ext(mem_sign_ext), .mem_access_addr(mem_access_addr),
    .val_input(val_input), .reg_addr_in(reg_addr_in),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_byte_en(bus_byte_en), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .val_output(val_output), .reg_addr_out(reg_addr_out), .reg_we(reg_we),
    .stall_for_mem(stall_for_mem), .addr_error(addr_error),
    .bad_vaddr(bad_vaddr), .fsm_state(fsm_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard compare.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (byte-lane view) ----------------
  function automatic logic [2:0] norm_size(input logic [2:0] s);
    return (s > 3'd4) ? 3'd2 : s;
  endfunction

  function automatic logic m_misaligned(input logic [2:0] s, input logic [31:0] a);
    if (s == 3'd1) return a[0];
    if (s == 3'd2) return (a[1:0] != 2'd0);
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] s, input int n);
    logic [3:0] be;
    for (int i = 0; i < 4; i++) begin
      case (s)
        3'd0:    be[i] = (i == n);
        3'd1:    be[i] = ((i / 2) == (n / 2));
        3'd3:    be[i] = (i <= n);
        3'd4:    be[i] = (i >= n);
        default: be[i] = 1'b1;
      endcase
    end
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] s, input int n, input logic [31:0] v);
    logic [31:0] w;
    logic [3:0]  be;
    be = m_be(s, n);
    w  = 32'd0;
    for (int i = 0; i < 4; i++) begin
      case (s)
        3'd0: w[8*i +: 8] = v[7:0];
        3'd1: w[8*i +: 8] = v[8*(i % 2) +: 8];
        3'd3: if (be[i]) w[8*i +: 8] = v[8*(3 - n + i) +: 8];
        3'd4: if (be[i]) w[8*i +: 8] = v[8*(i - n) +: 8];
        default: w[8*i +: 8] = v[8*i +: 8];
      endcase
    end
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] s, input logic sx, input int n,
                                         input logic [31:0] v, input logic [31:0] rdata);
    logic [31:0] r;
    logic [7:0]  b;
    logic [15:0] h;
    r = 32'd0;
    case (s)
      3'd0: begin
        b = rdata[8*n +: 8];
        r = {{24{sx & b[7]}}, b};
      end
      3'd1: begin
        h = rdata[16*(n / 2) +: 16];
        r = {{16{sx & h[15]}}, h};
      end
      3'd3: for (int j = 0; j < 4; j++)
              r[8*j +: 8] = (j >= 3 - n) ? rdata[8*(j - 3 + n) +: 8] : v[8*j +: 8];
      3'd4: for (int j = 0; j < 4; j++)
              r[8*j +: 8] = (j <= 3 - n) ? rdata[8*(j + n) +: 8] : v[8*j +: 8];
      default: r = rdata;
    endcase
    return r;
  endfunction

  function automatic vec_t mk(input logic [1:0] typ, input logic [2:0] size, input logic sext,
                              input logic [31:0] addr, input logic [31:0] val, input logic [4:0] rd,
                              input logic [31:0] rdata, input int delay, input logic err,
                              input logic [3:0] be, input logic [31:0] wd, input logic [31:0] ev);
    vec_t v;
    v.typ = typ; v.size = size; v.sext = sext; v.addr = addr; v.val = val; v.rd = rd;
    v.rdata = rdata; v.delay = delay; v.exp_err = err; v.exp_be = be;
    v.exp_wdata = wd; v.exp_val = ev;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_nop();
    mem_access_type = 2'd0;
    mem_access_size = 3'd2;
    mem_sign_ext    = 1'b0;
    mem_access_addr = 32'd0;
    val_input       = 32'd0;
    reg_addr_in     = 5'd0;
  endtask

  // Runs one instruction from the posedge after the call; returns at a negedge.
  task automatic do_access(input vec_t v, input int idx);
    logic is_load;
    logic is_store;
    int   stalls;
    is_load  = (v.typ == 2'd1);
    is_store = (v.typ == 2'd2);
    @(posedge clk); #1;
    mem_access_type = v.typ;
    mem_access_size = v.size;
    mem_sign_ext    = v.sext;
    mem_access_addr = v.addr;
    val_input       = v.val;
    reg_addr_in     = v.rd;
    bus_ack         = 1'b0;
    @(negedge clk);
    if (!is_load && !is_store) begin
      check($sformatf("v%0d_r2r_stall", idx), 32'(stall_for_mem), 32'd0);
      @(posedge clk); #1; drive_nop();
      @(negedge clk);
      check($sformatf("v%0d_r2r_val", idx), val_output, v.exp_val);
      check($sformatf("v%0d_r2r_rd", idx), 32'(reg_addr_out), 32'(v.rd));
      check($sformatf("v%0d_r2r_we", idx), 32'(reg_we), 32'(v.rd != 5'd0));
      check($sformatf("v%0d_r2r_req", idx), 32'(bus_req), 32'd0);
    end else if (v.exp_err) begin
      check($sformatf("v%0d_err_stall", idx), 32'(stall_for_mem), 32'd0);
      @(posedge clk); #1; drive_nop();
      @(negedge clk);
      check($sformatf("v%0d_err_flag", idx), 32'(addr_error), 32'd1);
      check($sformatf("v%0d_err_vaddr", idx), bad_vaddr, v.addr);
      check($sformatf("v%0d_err_req", idx), 32'(bus_req), 32'd0);
      check($sformatf("v%0d_err_we", idx), 32'(reg_we), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("v%0d_err_pulse", idx), 32'(addr_error), 32'd0);
    end else begin
      check($sformatf("v%0d_launch_stall", idx), 32'(stall_for_mem), 32'd1);
      stalls = 1;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_req", idx), 32'(bus_req), 32'd1);
      check($sformatf("v%0d_wr", idx), 32'(bus_wr), 32'(is_store));
      check($sformatf("v%0d_addr", idx), bus_addr, {v.addr[31:2], 2'b00});
      check($sformatf("v%0d_be", idx), 32'(bus_byte_en), 32'(v.exp_be));
      if (is_store) check($sformatf("v%0d_wdata", idx), bus_wdata, v.exp_wdata);
      check($sformatf("v%0d_busy_we", idx), 32'(reg_we), 32'd0);
      for (int k = 0; k < v.delay; k++) begin
        if (stall_for_mem) stalls++;
        if (k < v.delay - 1) begin
          @(posedge clk);
          @(negedge clk);
        end
      end
      check($sformatf("v%0d_hold_be", idx), 32'(bus_byte_en), 32'(v.exp_be));
      bus_ack   = 1'b1;
      bus_rdata = v.rdata;
      #1;
      check($sformatf("v%0d_ack_stall", idx), 32'(stall_for_mem), 32'd0);
      check($sformatf("v%0d_stall_cycles", idx), 32'(stalls), 32'(v.delay + 1));
      @(posedge clk); #1;
      bus_ack = 1'b0;
      drive_nop();
      @(negedge clk);
      check($sformatf("v%0d_done_req", idx), 32'(bus_req), 32'd0);
      check($sformatf("v%0d_done_state", idx), 32'(fsm_state), 32'd0);
      check($sformatf("v%0d_done_we", idx), 32'(reg_we), 32'(is_load && (v.rd != 5'd0)));
      if (is_load) begin
        check($sformatf("v%0d_load_val", idx), val_output, v.exp_val);
        check($sformatf("v%0d_load_rd", idx), 32'(reg_addr_out), 32'(v.rd));
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t v;
    logic [2:0] s;
    int n;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus_ack = 1'b0;
    bus_rdata = 32'd0;
    drive_nop();

    // Reset values.
    #2;
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_be", 32'(bus_byte_en), 32'd0);
    check("rst_val", val_output, 32'd0);
    check("rst_we", 32'(reg_we), 32'd0);
    check("rst_err", 32'(addr_error), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: typ,size,sext,addr,val,rd,rdata,delay,err,be,wdata,val_out.
    vecs.push_back(mk(2'd0, 3'd2, 1'b0, 32'h0,    32'h12345678, 5'd5,  32'h0,        1, 1'b0, 4'b0000, 32'h0,        32'h12345678));
    vecs.push_back(mk(2'd1, 3'd0, 1'b1, 32'h1003, 32'h0,        5'd9,  32'h80FFFFFF, 3, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80));
    vecs.push_back(mk(2'd2, 3'd1, 1'b0, 32'h2002, 32'hAAAA1234, 5'd4,  32'h0,        2, 1'b0, 4'b1100, 32'h12341234, 32'h0));
    vecs.push_back(mk(2'd1, 3'd2, 1'b0, 32'h3001, 32'h0,        5'd3,  32'h0,        1, 1'b1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(2'd1, 3'd3, 1'b0, 32'h4001, 32'hAABBCCDD, 5'd6,  32'h11223344, 1, 1'b0, 4'b0011, 32'h0,        32'h3344CCDD));
    vecs.push_back(mk(2'd2, 3'd4, 1'b0, 32'h5002, 32'hAABBCCDD, 5'd0,  32'h0,        2, 1'b0, 4'b1100, 32'hCCDD0000, 32'h0));
    vecs.push_back(mk(2'd1, 3'd0, 1'b0, 32'h1001, 32'h0,        5'd7,  32'h123480AA, 1, 1'b0, 4'b0010, 32'h0,        32'h00000080));
    vecs.push_back(mk(2'd1, 3'd1, 1'b1, 32'h2002, 32'h0,        5'd8,  32'h80017FFF, 2, 1'b0, 4'b1100, 32'h0,        32'hFFFF8001));
    vecs.push_back(mk(2'd1, 3'd1, 1'b0, 32'h2000, 32'h0,        5'd12, 32'h80017FFF, 1, 1'b0, 4'b0011, 32'h0,        32'h00007FFF));
    vecs.push_back(mk(2'd1, 3'd4, 1'b0, 32'h4005, 32'hAABBCCDD, 5'd10, 32'h11223344, 1, 1'b0, 4'b1110, 32'h0,        32'hAA112233));
    vecs.push_back(mk(2'd1, 3'd3, 1'b0, 32'h4007, 32'hAABBCCDD, 5'd11, 32'h11223344, 2, 1'b0, 4'b1111, 32'h0,        32'h11223344));
    vecs.push_back(mk(2'd2, 3'd3, 1'b0, 32'h5000, 32'hAABBCCDD, 5'd0,  32'h0,        1, 1'b0, 4'b0001, 32'h000000AA, 32'h0));
    vecs.push_back(mk(2'd2, 3'd0, 1'b0, 32'h6002, 32'h123456EE, 5'd0,  32'h0,        1, 1'b0, 4'b0100, 32'hEEEEEEEE, 32'h0));
    vecs.push_back(mk(2'd2, 3'd1, 1'b0, 32'h7001, 32'h0,        5'd0,  32'h0,        1, 1'b1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(2'd3, 3'd2, 1'b0, 32'h0,    32'hCAFEF00D, 5'd0,  32'h0,        1, 1'b0, 4'b0000, 32'h0,        32'hCAFEF00D));
    vecs.push_back(mk(2'd1, 3'd7, 1'b0, 32'h8000, 32'h0,        5'd31, 32'hDEADBEEF, 4, 1'b0, 4'b1111, 32'h0,        32'hDEADBEEF));
    vecs.push_back(mk(2'd1, 3'd2, 1'b0, 32'h8004, 32'h0,        5'd0,  32'h01020304, 1, 1'b0, 4'b1111, 32'h0,        32'h01020304));
    for (int i = 0; i < vecs.size(); i++) do_access(vecs[i], i);

    // bus_ack while IDLE has no effect on an R2R instruction.
    @(posedge clk); #1;
    mem_access_type = 2'd0; val_input = 32'h55AA55AA; reg_addr_in = 5'd7;
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("idle_ack_stall", 32'(stall_for_mem), 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0; drive_nop();
    @(negedge clk);
    check("idle_ack_val", val_output, 32'h55AA55AA);
    check("idle_ack_we", 32'(reg_we), 32'd1);
    check("idle_ack_req", 32'(bus_req), 32'd0);
    check("idle_ack_state", 32'(fsm_state), 32'd0);

    // Reset in BUSY abandons the access; a late ack does nothing.
    @(posedge clk); #1;
    mem_access_type = 2'd1; mem_access_size = 3'd2; mem_access_addr = 32'h9000; reg_addr_in = 5'd3;
    @(negedge clk);
    @(negedge clk);
    check("rbusy_req", 32'(bus_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rbusy_req_clr", 32'(bus_req), 32'd0);
    check("rbusy_state_clr", 32'(fsm_state), 32'd0);
    check("rbusy_addr_clr", bus_addr, 32'd0);
    drive_nop();
    @(negedge clk);
    rst_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check("rbusy_late_we", 32'(reg_we), 32'd0);
    check("rbusy_late_req", 32'(bus_req), 32'd0);
    check("rbusy_late_state", 32'(fsm_state), 32'd0);

    // Randomized accesses checked against the byte-lane model.
    for (int i = 0; i < 80; i++) begin
      v.typ   = 2'($urandom_range(0, 3));
      v.size  = 3'($urandom_range(0, 7));
      v.sext  = 1'($urandom_range(0, 1));
      v.addr  = $urandom;
      v.val   = $urandom;
      v.rd    = 5'($urandom_range(0, 31));
      v.rdata = $urandom;
      v.delay = $urandom_range(1, 4);
      s = norm_size(v.size);
      n = int'(v.addr[1:0]);
      v.exp_err   = ((v.typ == 2'd1) || (v.typ == 2'd2)) && m_misaligned(s, v.addr);
      v.exp_be    = m_be(s, n);
      v.exp_wdata = m_wdata(s, n, v.val);
      v.exp_val   = (v.typ == 2'd1) ? m_load(s, v.sext, n, v.val, v.rdata) : v.val;
      do_access(v, 100 + i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
